// File: rtl/hm_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hm_tx_pkg
// Description : Shared constants for the hm Memory Read request transmitter.
// Revision    : 1.0
// ============================================================================
package hm_tx_pkg;

    typedef enum logic [1:0] {
        HM_TX_STATE_IDLE = 2'b00,
        HM_TX_STATE_HDR  = 2'b01,
        HM_TX_STATE_ADDR = 2'b10,
        HM_TX_STATE_NEXT = 2'b11
    } hm_tx_state_t;

    // Memory Read fmt/type for 3-dword and 4-dword headers
    localparam logic [1:0] c_fmt_mrd_3dw = 2'b00;
    localparam logic [1:0] c_fmt_mrd_4dw = 2'b01;
    localparam logic [4:0] c_type_mrd    = 5'b00000;

    localparam logic [3:0] c_first_be    = 4'hF;
    localparam logic [3:0] c_last_be     = 4'hF;
    localparam logic [3:0] c_last_be_1dw = 4'h0;

    localparam int c_len_w = 11;

endpackage
`default_nettype wire

// File: rtl/hm_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : hm_tx_if
// Description : Virtex-6 trn transmit interface bundle.
// Revision    : 1.0
// ============================================================================
interface hm_tx_if;
    logic [63:0] trn_td;
    logic        trn_trem_n;
    logic        trn_tsof_n;
    logic        trn_teof_n;
    logic        trn_tsrc_rdy_n;
    logic        trn_tdst_rdy_n;
    logic [5:0]  trn_tbuf_av;
    logic        trn_tsrc_dsc_n;
    logic        trn_terrfwd_n;
    logic        trn_tstr_n;
    logic        trn_tcfg_gnt_n;

    modport master (
        output trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n,
        output trn_tsrc_dsc_n, trn_terrfwd_n, trn_tstr_n, trn_tcfg_gnt_n,
        input  trn_tdst_rdy_n, trn_tbuf_av
    );

    modport slave (
        input  trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n,
        input  trn_tsrc_dsc_n, trn_terrfwd_n, trn_tstr_n, trn_tcfg_gnt_n,
        output trn_tdst_rdy_n, trn_tbuf_av
    );
endinterface
`default_nettype wire

// File: rtl/hm_tx.sv
`default_nettype none
// ============================================================================
// Module      : hm_tx
// Description : Splits a host-memory fetch into aligned Memory Read TLPs.
// Revision    : 1.0
// ============================================================================
module hm_tx
    import hm_tx_pkg::*;
#(
    parameter int TOTAL_DW    = 2048,
    parameter int MAX_READ_DW = 32
) (
    input  logic        trn_clk,
    input  logic        trn_reset_n,
    input  logic        tx_start,
    output logic        tx_end,
    input  logic [63:0] hm_addr,
    input  logic [15:0] cfg_completer_id,
    input  logic        trn_lnk_up_n,
    hm_tx_if.master     tx,
    output logic [31:0] stat_trn_cpt_tx,
    output logic [1:0]  stat_state
);

    localparam int         c_rem_w    = $clog2(TOTAL_DW + 1);
    localparam logic [9:0] c_off_mask = 10'(MAX_READ_DW - 1);

    hm_tx_state_t         r_state;
    hm_tx_state_t         w_next_state;
    logic [63:0]          r_addr;
    logic [c_rem_w-1:0]   r_rem;
    logic [4:0]           r_tag;
    logic [31:0]          r_cpt;
    logic                 r_hdr_armed;

    logic [9:0]           w_offset;
    logic [c_len_w-1:0]   w_room;
    logic [c_len_w-1:0]   w_len;
    logic                 w_is_4dw;
    logic                 w_link;
    logic                 w_present_hdr;
    logic                 w_src_rdy;
    logic                 w_accept;
    logic [63:0]          w_td;
    logic                 w_trem_n;
    logic                 w_tsof_n;
    logic                 w_teof_n;
    logic                 w_tx_end;
    logic                 w_unused;

    function automatic logic [63:0] hdr_beat(
        input logic               is_4dw,
        input logic [c_len_w-1:0] len,
        input logic [15:0]        req_id,
        input logic [4:0]         tag
    );
        logic [31:0] dw0;
        logic [31:0] dw1;
        dw0 = {1'b0, (is_4dw ? c_fmt_mrd_4dw : c_fmt_mrd_3dw), c_type_mrd,
               1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, len[9:0]};
        dw1 = {req_id, 3'b000, tag, ((len > 11'd1) ? c_last_be : c_last_be_1dw), c_first_be};
        return {dw0, dw1};
    endfunction

    // Room left before the next MAX_READ_DW*4-byte boundary
    assign w_offset = r_addr[11:2] & c_off_mask;
    assign w_room   = 11'(MAX_READ_DW) - {1'b0, w_offset};
    assign w_len    = (32'(r_rem) < 32'(w_room)) ? 11'(r_rem) : w_room;
    assign w_is_4dw = |r_addr[63:32];

    assign w_link        = ~trn_lnk_up_n;
    // Once beat 1 is offered it stays offered even if tbuf_av drops
    assign w_present_hdr = (r_state == HM_TX_STATE_HDR) && (r_hdr_armed || (tx.trn_tbuf_av != 6'd0));
    assign w_src_rdy     = w_link && (w_present_hdr || (r_state == HM_TX_STATE_ADDR));
    assign w_accept      = w_src_rdy && ~tx.trn_tdst_rdy_n;

    always_ff @(posedge trn_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            r_state <= HM_TX_STATE_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_td         = 64'd0;
        w_trem_n     = 1'b0;
        w_tsof_n     = 1'b1;
        w_teof_n     = 1'b1;
        w_tx_end     = 1'b0;
        unique case (r_state)
            HM_TX_STATE_IDLE: begin
                if (tx_start && w_link) begin
                    w_next_state = HM_TX_STATE_HDR;
                end
            end
            HM_TX_STATE_HDR: begin
                if (w_present_hdr) begin
                    w_td     = hdr_beat(w_is_4dw, w_len, cfg_completer_id, r_tag);
                    w_tsof_n = 1'b0;
                end
                if (w_accept) begin
                    w_next_state = HM_TX_STATE_ADDR;
                end
            end
            HM_TX_STATE_ADDR: begin
                w_teof_n = 1'b0;
                w_td     = w_is_4dw ? r_addr : {r_addr[31:0], 32'h0};
                w_trem_n = ~w_is_4dw;
                if (w_accept) begin
                    w_next_state = HM_TX_STATE_NEXT;
                end
            end
            HM_TX_STATE_NEXT: begin
                if (r_rem == '0) begin
                    w_tx_end     = 1'b1;
                    w_next_state = HM_TX_STATE_IDLE;
                end else begin
                    w_next_state = HM_TX_STATE_HDR;
                end
            end
            default: w_next_state = HM_TX_STATE_IDLE;
        endcase
        if (!w_link) begin
            w_next_state = HM_TX_STATE_IDLE;
            w_tx_end     = 1'b0;
        end
    end

    always_ff @(posedge trn_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            r_addr      <= 64'd0;
            r_rem       <= '0;
            r_tag       <= 5'd0;
            r_cpt       <= 32'd0;
            r_hdr_armed <= 1'b0;
        end else begin
            r_hdr_armed <= w_link && w_present_hdr && ~w_accept;
            if ((r_state == HM_TX_STATE_IDLE) && tx_start && w_link) begin
                r_addr <= {hm_addr[63:2], 2'b00};
                r_rem  <= c_rem_w'(TOTAL_DW);
                r_tag  <= 5'd0;
            end else if ((r_state == HM_TX_STATE_ADDR) && w_accept) begin
                r_cpt  <= r_cpt + 32'd1;
                r_addr <= r_addr + {51'd0, w_len, 2'b00};
                r_rem  <= r_rem - c_rem_w'(w_len);
                r_tag  <= r_tag + 5'd1;
            end
        end
    end

    assign tx.trn_td         = w_td;
    assign tx.trn_trem_n     = w_trem_n;
    assign tx.trn_tsof_n     = w_tsof_n;
    assign tx.trn_teof_n     = w_teof_n;
    assign tx.trn_tsrc_rdy_n = ~w_src_rdy;
    assign tx.trn_tsrc_dsc_n = 1'b1;
    assign tx.trn_terrfwd_n  = 1'b1;
    assign tx.trn_tstr_n     = 1'b1;
    assign tx.trn_tcfg_gnt_n = 1'b0;

    assign tx_end          = w_tx_end;
    assign stat_trn_cpt_tx = r_cpt;
    assign stat_state      = r_state;

    assign w_unused = &{1'b0, hm_addr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_hm_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_hm_tx
// Description : Directed + randomized bench for hm_tx with a request-list model.
// Revision    : 1.0
// ============================================================================
module tb_hm_tx;

    localparam int TOTAL_DW    = 2048;
    localparam int MAX_READ_DW = 32;

    typedef struct packed {
        logic        trem;
        logic        sof;
        logic        eof;
        logic [63:0] td;
    } beat_t;

    logic        trn_clk = 1'b0;
    logic        trn_reset_n;
    logic        tx_start;
    logic        tx_end;
    logic [63:0] hm_addr;
    logic [15:0] cfg_completer_id;
    logic        trn_lnk_up_n;
    logic [31:0] stat_trn_cpt_tx;
    logic [1:0]  stat_state;

    hm_tx_if tx_if ();

    hm_tx #(.TOTAL_DW(TOTAL_DW), .MAX_READ_DW(MAX_READ_DW)) u_dut (
        .trn_clk          (trn_clk),
        .trn_reset_n      (trn_reset_n),
        .tx_start         (tx_start),
        .tx_end           (tx_end),
        .hm_addr          (hm_addr),
        .cfg_completer_id (cfg_completer_id),
        .trn_lnk_up_n     (trn_lnk_up_n),
        .tx               (tx_if),
        .stat_trn_cpt_tx  (stat_trn_cpt_tx),
        .stat_state       (stat_state)
    );

    always #5 trn_clk = ~trn_clk;

    int    n_pass  = 0;
    int    n_total = 0;
    int    exp_stat = 0;
    beat_t exp_q[$];
    beat_t got[$];

    task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Expected beat list: walk the transfer in byte addresses, cutting at each block boundary
    task automatic model(input logic [63:0] a);
        longint unsigned addr, blk;
        int              rem, tag, room, len;
        bit              four;
        logic [31:0]     dw0, dw1;
        exp_q.delete();
        addr = {a[63:2], 2'b00};
        rem  = TOTAL_DW;
        tag  = 0;
        blk  = longint'(MAX_READ_DW) * 4;
        while (rem > 0) begin
            room = int'((blk - (addr % blk)) / 4);
            len  = (rem < room) ? rem : room;
            four = (addr >> 32) != 0;
            dw0  = (four ? 32'h2000_0000 : 32'h0) | 32'(len % 1024);
            dw1  = {cfg_completer_id, 16'h0} | 32'((tag % 32) << 8) | ((len > 1) ? 32'hFF : 32'h0F);
            exp_q.push_back({1'b0, 1'b0, 1'b1, dw0, dw1});
            if (four) exp_q.push_back({1'b0, 1'b1, 1'b0, 64'(addr)});
            else      exp_q.push_back({1'b1, 1'b1, 1'b0, addr[31:0], 32'h0});
            addr += longint'(len) * 4;
            rem  -= len;
            tag++;
        end
    endtask

    task automatic start_pulse(input logic [63:0] a);
        @(posedge trn_clk); #1;
        hm_addr  = a;
        tx_start = 1'b1;
        @(posedge trn_clk); #1;
        tx_start = 1'b0;
        hm_addr  = {$urandom, $urandom};
    endtask

    // Runs one transfer with random backpressure, captures accepted beats, scores them
    task automatic run_transfer(input string tag, input logic [63:0] a, input int bp_pct, input bit poke);
        int cyc, ends, last_acc, end_at, first_sof;
        beat_t b;
        model(a);
        got.delete();
        tx_if.trn_tdst_rdy_n = 1'b0;
        start_pulse(a);
        cyc = 0; ends = 0; last_acc = -1; end_at = -1; first_sof = -1;
        while (cyc < 6000 && (end_at < 0 || cyc < end_at + 3)) begin
            @(negedge trn_clk);
            if (!tx_if.trn_tsrc_rdy_n && !tx_if.trn_tsof_n && first_sof < 0) first_sof = cyc;
            if (!tx_if.trn_tsrc_rdy_n && !tx_if.trn_tdst_rdy_n) begin
                b = {tx_if.trn_trem_n, tx_if.trn_tsof_n, tx_if.trn_teof_n, tx_if.trn_td};
                got.push_back(b);
                last_acc = cyc;
            end
            if (tx_end) begin
                ends++;
                if (end_at < 0) end_at = cyc;
            end
            @(posedge trn_clk); #1;
            tx_if.trn_tdst_rdy_n = ($urandom_range(99) < bp_pct);
            tx_start = poke && (cyc == 10);
            cyc++;
        end
        tx_start = 1'b0;
        tx_if.trn_tdst_rdy_n = 1'b0;
        chk({tag, "_sof_latency"}, first_sof, 0);
        chk({tag, "_end_pulses"}, ends, 1);
        chk({tag, "_end_latency"}, end_at, last_acc + 1);
        chk({tag, "_beats"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("%s_beat%0d", tag, i), got[i], exp_q[i]);
        exp_stat += exp_q.size() / 2;
        chk({tag, "_stat_cpt"}, stat_trn_cpt_tx, exp_stat);
    endtask

    task automatic wait_end(input string tag);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(negedge trn_clk);
            seen = tx_end;
        end
        chk(tag, seen, 1'b1);
    endtask

    initial begin
        int acc;
        logic [63:0] ra;
        trn_reset_n          = 1'b0;
        tx_start             = 1'b0;
        hm_addr              = 64'd0;
        cfg_completer_id     = 16'h0100;
        trn_lnk_up_n         = 1'b0;
        tx_if.trn_tdst_rdy_n = 1'b0;
        tx_if.trn_tbuf_av    = 6'd1;

        // Reset state
        #22;
        chk("rst_ctl", {tx_if.trn_tsrc_rdy_n, tx_if.trn_tsof_n, tx_if.trn_teof_n, tx_if.trn_trem_n, tx_end, stat_state}, 7'b1110_000);
        chk("rst_td", tx_if.trn_td, 64'd0);
        chk("rst_stat", stat_trn_cpt_tx, 0);
        chk("tied", {tx_if.trn_tsrc_dsc_n, tx_if.trn_terrfwd_n, tx_if.trn_tstr_n, tx_if.trn_tcfg_gnt_n}, 4'b1110);
        @(posedge trn_clk); #1;
        trn_reset_n = 1'b1;

        // 1: aligned 3-dword transfer, no backpressure
        run_transfer("t1", 64'h0000_0000_1000_0000, 0, 1'b0);
        chk("t1_b0", got[0], {3'b001, 64'h0000_0020_0100_00FF});
        chk("t1_b1", got[1], {3'b110, 64'h1000_0000_0000_0000});
        chk("t1_tlps", got.size(), 128);
        chk("t1_tag_wrap", got[64].td[12:8], 5'd0);

        // 2: 4-dword headers above 4 GB
        run_transfer("t2", 64'h0000_0001_0000_0000, 0, 1'b0);
        chk("t2_dw0", got[0].td[63:32], 32'h2000_0020);
        chk("t2_b1", got[1], {3'b010, 64'h0000_0001_0000_0000});

        // 3: misaligned start gives 16, 63x32, 16
        run_transfer("t3", 64'h0000_0000_1000_0040, 0, 1'b0);
        chk("t3_tlps", got.size(), 130);
        chk("t3_len_first", got[0].td[41:32], 10'd16);
        chk("t3_addr2", got[3].td[63:32], 32'h1000_0080);
        chk("t3_len_last", got[128].td[41:32], 10'd16);

        // 4: crossing 4 GB switches header format
        run_transfer("t4", 64'h0000_0000_FFFF_FF80, 0, 1'b0);
        chk("t4_b1", got[1], {3'b110, 64'hFFFF_FF80_0000_0000});
        chk("t4_dw0_next", got[2].td[63:32], 32'h2000_0020);
        chk("t4_b3", got[3], {3'b010, 64'h0000_0001_0000_0000});

        // 5a: destination stall on beat 1
        model(64'h0000_0000_2000_0000);
        tx_if.trn_tdst_rdy_n = 1'b1;
        start_pulse(64'h0000_0000_2000_0000);
        tx_if.trn_tdst_rdy_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge trn_clk);
            chk($sformatf("bp_hold%0d", i), {tx_if.trn_trem_n, tx_if.trn_tsof_n, tx_if.trn_teof_n, tx_if.trn_td}, exp_q[0]);
            chk($sformatf("bp_state%0d", i), {tx_if.trn_tsrc_rdy_n, stat_state}, 3'b001);
        end
        @(posedge trn_clk); #1;
        tx_if.trn_tdst_rdy_n = 1'b0;
        wait_end("bp_end");
        exp_stat += 64;
        chk("bp_stat", stat_trn_cpt_tx, exp_stat);

        // 5b: no transmit buffers
        tx_if.trn_tbuf_av = 6'd0;
        start_pulse(64'h0000_0000_3000_0000);
        for (int i = 0; i < 4; i++) begin
            @(negedge trn_clk);
            chk($sformatf("tbuf_wait%0d", i), {tx_if.trn_tsrc_rdy_n, stat_state}, 3'b101);
        end
        @(posedge trn_clk); #1;
        tx_if.trn_tbuf_av = 6'd3;
        @(negedge trn_clk);
        chk("tbuf_go", {tx_if.trn_tsrc_rdy_n, tx_if.trn_tsof_n}, 2'b00);
        wait_end("tbuf_end");
        exp_stat += 64;
        tx_if.trn_tbuf_av = 6'd1;

        // 6a: reset during beat 2, then restart from tag 0
        start_pulse(64'h0000_0000_4000_0000);
        @(posedge trn_clk); #1;
        tx_if.trn_tdst_rdy_n = 1'b1;
        @(negedge trn_clk);
        chk("rst_mid_pre", {stat_state, tx_if.trn_teof_n}, 3'b100);
        #2 trn_reset_n = 1'b0;
        #1;
        chk("rst_mid_ctl", {tx_if.trn_tsrc_rdy_n, tx_if.trn_tsof_n, tx_if.trn_teof_n, tx_if.trn_trem_n, tx_end, stat_state}, 7'b1110_000);
        chk("rst_mid_td", tx_if.trn_td, 64'd0);
        chk("rst_mid_stat", stat_trn_cpt_tx, 0);
        @(posedge trn_clk); #1;
        trn_reset_n = 1'b1;
        tx_if.trn_tdst_rdy_n = 1'b0;
        exp_stat = 0;
        run_transfer("t6", 64'h0000_0000_4000_0000, 0, 1'b0);

        // 6b: link drop mid-transfer, start ignored while link down
        acc = 0;
        start_pulse(64'h0000_0000_5000_0000);
        for (int i = 0; i < 20; i++) begin
            @(negedge trn_clk);
            if (!tx_if.trn_tsrc_rdy_n && !tx_if.trn_tdst_rdy_n && !tx_if.trn_teof_n) acc++;
            @(posedge trn_clk); #1;
        end
        trn_lnk_up_n = 1'b1;
        @(negedge trn_clk);
        chk("lnk_src_rdy", tx_if.trn_tsrc_rdy_n, 1'b1);
        @(posedge trn_clk); #1;
        tx_start = 1'b1;
        @(negedge trn_clk);
        chk("lnk_idle", {stat_state, tx_end}, 3'b000);
        @(posedge trn_clk); #1;
        tx_start = 1'b0;
        @(negedge trn_clk);
        chk("lnk_start_ignored", {stat_state, tx_end, tx_if.trn_tsrc_rdy_n}, 4'b0001);
        exp_stat += acc;
        chk("lnk_stat", stat_trn_cpt_tx, exp_stat);
        @(posedge trn_clk); #1;
        trn_lnk_up_n = 1'b0;

        // Randomized transfers under backpressure, one with a start poke while busy
        for (int k = 0; k < 4; k++) begin
            cfg_completer_id = 16'($urandom);
            ra = (k % 2 == 0) ? {32'h0, 32'hFFFF_F000 | 32'($urandom_range(4095))} : {$urandom, $urandom};
            run_transfer($sformatf("rnd%0d", k), ra, 30, k == 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
